// File: rtl/serial_tx_4.sv
// serial_tx_4: parallel-in/serial-out frame transmitter.
// Accepts a DATA_W-bit word on a valid/ready handshake and sends it as
// start(0) + data LSB-first + stop(1). Each bit is held CLKS_PER_BIT cycles.
//
// Ports:
//   clk        clock; all state changes on its rising edge
//   reset      synchronous active-low reset
//   tx_valid   producer has a word on tx_data
//   tx_data    word to send, sampled only on acceptance
//   tx_ready   block can accept a word this cycle (combinational from state)
//   tx_serial  serial line, idle high, registered
//   tx_busy    frame in progress, registered
module serial_tx_4 #(
  parameter int unsigned DATA_W       = 4,
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tx_valid,
  input  logic [DATA_W-1:0] tx_data,
  output logic              tx_ready,
  output logic              tx_serial,
  output logic              tx_busy
);

  // Counters are at least one bit wide so a value of 1 still gives a legal vector.
  localparam int unsigned TimerW = $clog2((CLKS_PER_BIT > 2) ? CLKS_PER_BIT : 2);
  localparam int unsigned IdxW   = $clog2((DATA_W > 2) ? DATA_W : 2);
  localparam logic [TimerW-1:0] TimerMax = TimerW'(CLKS_PER_BIT - 1);
  localparam logic [IdxW-1:0]   IdxMax   = IdxW'(DATA_W - 1);

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StData,
    StStop
  } state_e;

  state_e              state_q;
  logic [DATA_W-1:0]   shift_q;
  logic [TimerW-1:0]   timer_q;
  logic [IdxW-1:0]     idx_q;
  logic                serial_q;
  logic                busy_q;

  logic [DATA_W-1:0]   shift_nx;
  logic                bit_done;

  assign shift_nx  = shift_q >> 1;
  assign bit_done  = (timer_q == TimerMax);

  assign tx_ready  = (state_q == StIdle) && reset;
  assign tx_serial = serial_q;
  assign tx_busy   = busy_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      // Aborts any frame in flight; the line goes high on this edge.
      state_q  <= StIdle;
      shift_q  <= '0;
      timer_q  <= '0;
      idx_q    <= '0;
      serial_q <= 1'b1;
      busy_q   <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          serial_q <= 1'b1;
          busy_q   <= 1'b0;
          timer_q  <= '0;
          idx_q    <= '0;
          // tx_ready is 1 here, so tx_valid alone means acceptance.
          if (tx_valid) begin
            shift_q  <= tx_data;
            state_q  <= StStart;
            serial_q <= 1'b0;
            busy_q   <= 1'b1;
          end
        end
        StStart: begin
          if (bit_done) begin
            timer_q  <= '0;
            idx_q    <= '0;
            state_q  <= StData;
            serial_q <= shift_q[0];
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        StData: begin
          if (bit_done) begin
            timer_q <= '0;
            shift_q <= shift_nx;
            if (idx_q == IdxMax) begin
              state_q  <= StStop;
              serial_q <= 1'b1;
            end else begin
              idx_q    <= idx_q + 1'b1;
              // Next bit comes from the post-shift value so the line is registered.
              serial_q <= shift_nx[0];
            end
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        StStop: begin
          if (bit_done) begin
            timer_q <= '0;
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        default: begin
          state_q  <= StIdle;
          serial_q <= 1'b1;
          busy_q   <= 1'b0;
          timer_q  <= '0;
          idx_q    <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_tx_4.sv
// Bench for serial_tx_4: a 4-bit/4-clock instance and an 8-bit/1-clock instance.
// Expected {serial, ready, busy} per cycle are queued when stimulus is driven
// and compared at the following falling edges.
module tb_serial_tx_4;

  typedef struct packed {
    logic ser;
    logic rdy;
    logic bsy;
  } exp_t;

  // Expected serial waveform, first cycle in the MSB, one nibble per bit slot.
  typedef struct {
    logic [3:0]  data;
    logic [23:0] wave;
  } vec_t;

  logic       clk;
  logic       reset;
  logic       valid0;
  logic [3:0] data0;
  logic       ready0;
  logic       serial0;
  logic       busy0;
  logic       valid1;
  logic [7:0] data1;
  logic       ready1;
  logic       serial1;
  logic       busy1;

  exp_t q0[$];
  exp_t q1[$];
  int   total;
  int   bad;
  int   cyc;

  serial_tx_4 #(
    .DATA_W      (4),
    .CLKS_PER_BIT(4)
  ) dut0 (
    .clk      (clk),
    .reset    (reset),
    .tx_valid (valid0),
    .tx_data  (data0),
    .tx_ready (ready0),
    .tx_serial(serial0),
    .tx_busy  (busy0)
  );

  serial_tx_4 #(
    .DATA_W      (8),
    .CLKS_PER_BIT(1)
  ) dut1 (
    .clk      (clk),
    .reset    (reset),
    .tx_valid (valid1),
    .tx_data  (data1),
    .tx_ready (ready1),
    .tx_serial(serial1),
    .tx_busy  (busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock: check at the falling edge, then return 1 time unit after the rising edge.
  task automatic cycle(input string tag);
    exp_t e;
    @(negedge clk);
    cyc++;
    if (q0.size() != 0) begin
      e = q0.pop_front();
      total++;
      if ({serial0, ready0, busy0} !== e) begin
        bad++;
        $display("FAIL %s dut0 cyc=%0d got ser/rdy/bsy=%b%b%b want %b%b%b", tag, cyc,
                 serial0, ready0, busy0, e.ser, e.rdy, e.bsy);
      end
    end
    if (q1.size() != 0) begin
      e = q1.pop_front();
      total++;
      if ({serial1, ready1, busy1} !== e) begin
        bad++;
        $display("FAIL %s dut1 cyc=%0d got ser/rdy/bsy=%b%b%b want %b%b%b", tag, cyc,
                 serial1, ready1, busy1, e.ser, e.rdy, e.bsy);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string tag);
    int guard;
    guard = 0;
    while ((q0.size() != 0 || q1.size() != 0) && guard < 500) begin
      cycle(tag);
      guard++;
    end
    if (q0.size() != 0 || q1.size() != 0) begin
      total++;
      bad++;
      $display("FAIL %s drain timeout left=%0d want 0", tag, q0.size() + q1.size());
      q0.delete();
      q1.delete();
    end
  endtask

  // 24 frame cycles followed by the idle/ready cycle.
  task automatic push_frame0(input logic [23:0] wave);
    for (int i = 0; i < 24; i++) q0.push_back('{ser: wave[23-i], rdy: 1'b0, bsy: 1'b1});
    q0.push_back('{ser: 1'b1, rdy: 1'b1, bsy: 1'b0});
  endtask

  initial begin
    vec_t        vecs[6];
    logic [9:0]  wave1;
    int          n;

    vecs[0] = '{data: 4'hA, wave: 24'h00F0FF};
    vecs[1] = '{data: 4'h3, wave: 24'h0FF00F};
    vecs[2] = '{data: 4'hC, wave: 24'h000FFF};
    vecs[3] = '{data: 4'h0, wave: 24'h00000F};
    vecs[4] = '{data: 4'hF, wave: 24'h0FFFFF};
    vecs[5] = '{data: 4'h5, wave: 24'h0F0F0F};

    total  = 0;
    bad    = 0;
    cyc    = 0;
    reset  = 1'b0;
    valid0 = 1'b1;
    data0  = 4'hF;
    valid1 = 1'b1;
    data1  = 8'hFF;
    @(posedge clk);
    #1;

    // Reset held with valid high: line idle, not ready, nothing starts.
    for (int i = 0; i < 3; i++) begin
      q0.push_back('{ser: 1'b1, rdy: 1'b0, bsy: 1'b0});
      q1.push_back('{ser: 1'b1, rdy: 1'b0, bsy: 1'b0});
    end
    drain("reset");
    valid0 = 1'b0;
    valid1 = 1'b0;
    reset  = 1'b1;
    q0.push_back('{ser: 1'b1, rdy: 1'b1, bsy: 1'b0});
    q1.push_back('{ser: 1'b1, rdy: 1'b1, bsy: 1'b0});
    drain("release");

    // Single words; tx_data is scrambled two cycles after acceptance.
    for (int v = 0; v < 6; v++) begin
      valid0 = 1'b1;
      data0  = vecs[v].data;
      q0.push_back('{ser: 1'b1, rdy: 1'b1, bsy: 1'b0});
      push_frame0(vecs[v].wave);
      cycle("single");
      valid0 = 1'b0;
      cycle("single");
      cycle("single");
      data0 = ~vecs[v].data;
      drain("single");
    end

    // Back-to-back 3 then C with valid held: period 25.
    valid0 = 1'b1;
    data0  = vecs[1].data;
    q0.push_back('{ser: 1'b1, rdy: 1'b1, bsy: 1'b0});
    push_frame0(vecs[1].wave);
    push_frame0(vecs[2].wave);
    cycle("b2b");
    data0 = vecs[2].data;
    for (int i = 0; i < 25; i++) cycle("b2b");
    valid0 = 1'b0;
    drain("b2b");

    // Reset during DATA bit 2 of 4'hA (bit value 0, so the line visibly returns high).
    valid0 = 1'b1;
    data0  = 4'hA;
    q0.push_back('{ser: 1'b1, rdy: 1'b1, bsy: 1'b0});
    for (int i = 0; i < 14; i++) q0.push_back('{ser: vecs[0].wave[23-i], rdy: 1'b0, bsy: 1'b1});
    q0.push_back('{ser: 1'b1, rdy: 1'b0, bsy: 1'b0});
    cycle("midrst");
    valid0 = 1'b0;
    for (int i = 0; i < 13; i++) cycle("midrst");
    reset = 1'b0;
    cycle("midrst");
    cycle("midrst");
    reset = 1'b1;
    q0.push_back('{ser: 1'b1, rdy: 1'b1, bsy: 1'b0});
    drain("midrst");
    valid0 = 1'b1;
    data0  = 4'hF;
    q0.push_back('{ser: 1'b1, rdy: 1'b1, bsy: 1'b0});
    push_frame0(vecs[4].wave);
    cycle("after_rst");
    valid0 = 1'b0;
    drain("after_rst");

    // One clock per bit, 8-bit word 8'h81: 0,1,0,0,0,0,0,0,1,1 then ready.
    wave1  = 10'b0100000011;
    n      = 10;
    valid1 = 1'b1;
    data1  = 8'h81;
    q1.push_back('{ser: 1'b1, rdy: 1'b1, bsy: 1'b0});
    for (int i = 0; i < n; i++) q1.push_back('{ser: wave1[9-i], rdy: 1'b0, bsy: 1'b1});
    q1.push_back('{ser: 1'b1, rdy: 1'b1, bsy: 1'b0});
    cycle("cpb1");
    valid1 = 1'b0;
    data1  = 8'h00;
    drain("cpb1");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
